// File: rtl/booth_mac_pkg.sv
// Shared definitions for the Booth multiply-accumulate sequencer.
// Holds the FSM state encoding, the operand/product widths and the default accumulator/counter widths.
package booth_mac_pkg;

  localparam int unsigned OP_W      = 8;
  localparam int unsigned PROD_W    = 16;
  localparam int unsigned ACC_W_DEF = 24;
  localparam int unsigned CNT_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    ACCUM = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/booth_mac_sat_add.sv
// Combinational signed adder with an overflow flag.
// When SATURATE_EN is defined, overflow clamps the sum to the signed range; otherwise the sum wraps.
module booth_mac_sat_add
  import booth_mac_pkg::*;
#(
  parameter int unsigned W = ACC_W_DEF
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum_c,
  output logic         ovf_c
);

  logic [W-1:0] raw;

  assign raw   = a + b;
  assign ovf_c = (a[W-1] == b[W-1]) && (raw[W-1] != a[W-1]);

`ifdef SATURATE_EN
  // Both operands share a sign on overflow, so a's sign picks the rail.
  assign sum_c = !ovf_c  ? raw :
                 a[W-1]  ? {1'b1, {(W-1){1'b0}}} :
                           {1'b0, {(W-1){1'b1}}};
`else
  assign sum_c = raw;
`endif

endmodule

// File: rtl/booth_mac_ctrl.sv
// MAC sequencer: feeds operand pairs to a Booth multiplier and accumulates one signed result per frame.
// Optional SATURATE_EN clamps the accumulator on signed overflow and reports it on acc_sat.
module booth_mac_ctrl
  import booth_mac_pkg::*;
#(
  parameter int unsigned ACC_W = ACC_W_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   in_a,
  input  logic [OP_W-1:0]   in_b,
  input  logic              in_last,
  output logic              start_sig,
  output logic [OP_W-1:0]   A,
  output logic [OP_W-1:0]   B,
  input  logic              done_sig,
  input  logic [PROD_W-1:0] product,
  output logic              acc_done_sig,
  output logic [ACC_W-1:0]  acc_result,
  output logic [CNT_W-1:0]  acc_terms,
  output logic              acc_sat
);

  state_t             state;
  logic               last_q;
  logic [ACC_W-1:0]   prod_q;
  logic [ACC_W-1:0]   acc_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [ACC_W-1:0]   sum_c;
  logic               add_ovf;
  logic [CNT_W-1:0]   cnt_inc;

  assign cnt_inc = cnt_q + CNT_W'(1);

  booth_mac_sat_add #(.W(ACC_W)) u_add (
    .a     (acc_q),
    .b     (prod_q),
    .sum_c (sum_c),
    .ovf_c (add_ovf)
  );

`ifdef SATURATE_EN
  logic sat_q;
`else
  logic unused_ovf;
  assign unused_ovf = add_ovf;
  assign acc_sat    = 1'b0;
`endif

  // Frame result is registered on the ACCUM->DONE edge so acc_done_sig is high exactly during DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      in_ready     <= 1'b0;
      start_sig    <= 1'b0;
      A            <= '0;
      B            <= '0;
      last_q       <= 1'b0;
      prod_q       <= '0;
      acc_q        <= '0;
      cnt_q        <= '0;
      acc_done_sig <= 1'b0;
      acc_result   <= '0;
      acc_terms    <= '0;
`ifdef SATURATE_EN
      sat_q        <= 1'b0;
      acc_sat      <= 1'b0;
`endif
    end else begin
      acc_done_sig <= 1'b0;
      case (state)
        IDLE: begin
          in_ready <= 1'b1;
          if (in_valid && in_ready) begin
            A         <= in_a;
            B         <= in_b;
            last_q    <= in_last;
            start_sig <= 1'b1;
            in_ready  <= 1'b0;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          if (done_sig) begin
            prod_q    <= ACC_W'($signed(product));
            start_sig <= 1'b0;
            state     <= ACCUM;
          end
        end
        ACCUM: begin
          acc_q <= sum_c;
          cnt_q <= cnt_inc;
`ifdef SATURATE_EN
          sat_q <= sat_q | add_ovf;
`endif
          if (last_q) begin
            acc_result   <= sum_c;
            acc_terms    <= cnt_inc;
            acc_done_sig <= 1'b1;
`ifdef SATURATE_EN
            acc_sat      <= sat_q | add_ovf;
`endif
            state        <= DONE;
          end else begin
            in_ready <= 1'b1;
            state    <= IDLE;
          end
        end
        DONE: begin
          acc_q    <= '0;
          cnt_q    <= '0;
`ifdef SATURATE_EN
          sat_q    <= 1'b0;
`endif
          in_ready <= 1'b1;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_mac_ctrl.sv
// Scoreboard bench for booth_mac_ctrl at ACC_W=24 and ACC_W=16, driven by a behavioural Booth multiplier.
// Expected frame sums follow SATURATE_EN when it is defined.
module tb_booth_mac_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [7:0]  in_a;
  logic [7:0]  in_b;
  logic        in_last;
  logic        done_sig;
  logic [15:0] product;

  logic        in_ready, start_sig, acc_done_sig, acc_sat;
  logic [7:0]  A, B, acc_terms;
  logic [23:0] acc_result;

  logic        in_ready16, start_sig16, acc_done_sig16, acc_sat16;
  logic [7:0]  a16, b16, acc_terms16;
  logic [15:0] acc_result16;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_done_cyc = 0;
  int mul_lat = 2;
  int mul_cnt;

  typedef struct {
    logic [23:0] r24;
    logic [15:0] r16;
    logic [7:0]  terms;
    logic        sat24;
    logic        sat16;
  } exp_t;

  exp_t  sb_q[$];
  exp_t  e;
  logic [23:0] last_r24 = '0;

  longint m24 = 0, m16 = 0;
  int     mterms = 0;
  bit     msat24 = 0, msat16 = 0;

  booth_mac_ctrl #(.ACC_W(24), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_last(in_last), .start_sig(start_sig),
    .A(A), .B(B), .done_sig(done_sig), .product(product),
    .acc_done_sig(acc_done_sig), .acc_result(acc_result),
    .acc_terms(acc_terms), .acc_sat(acc_sat)
  );

  booth_mac_ctrl #(.ACC_W(16), .CNT_W(8)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready16),
    .in_a(in_a), .in_b(in_b), .in_last(in_last), .start_sig(start_sig16),
    .A(a16), .B(b16), .done_sig(done_sig), .product(product),
    .acc_done_sig(acc_done_sig16), .acc_result(acc_result16),
    .acc_terms(acc_terms16), .acc_sat(acc_sat16)
  );

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural multiplier: done_sig pulses mul_lat cycles into a start_sig request.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_sig <= 1'b0;
      product  <= '0;
      mul_cnt  <= 0;
    end else begin
      done_sig <= 1'b0;
      if (start_sig && !done_sig) begin
        if (mul_cnt + 1 >= mul_lat) begin
          done_sig <= 1'b1;
          product  <= 16'($signed(A) * $signed(B));
          mul_cnt  <= 0;
        end else begin
          mul_cnt <= mul_cnt + 1;
        end
      end
    end
  end

  function automatic longint wrapw(longint v, int w);
    longint m;
    m = v & ((longint'(1) << w) - 1);
    if (m >= (longint'(1) << (w - 1))) m = m - (longint'(1) << w);
    return m;
  endfunction

  function automatic longint mac_step(longint acc, longint p, int w, output bit ovf);
    longint s, mx, mn;
    s   = acc + p;
    mx  = (longint'(1) << (w - 1)) - 1;
    mn  = -(longint'(1) << (w - 1));
    ovf = (s > mx) || (s < mn);
`ifdef SATURATE_EN
    if (s > mx) return mx;
    if (s < mn) return mn;
    return s;
`else
    return wrapw(s, w);
`endif
  endfunction

  task automatic model_clear();
    m24 = 0; m16 = 0; mterms = 0; msat24 = 0; msat16 = 0;
  endtask

  task automatic model_term(input int a, input int b, input bit last);
    longint p;
    bit o;
    exp_t x;
    p = longint'(a) * longint'(b);
    m24 = mac_step(m24, p, 24, o); msat24 |= o;
    m16 = mac_step(m16, p, 16, o); msat16 |= o;
    mterms++;
    if (last) begin
      x.r24   = 24'(m24);
      x.r16   = 16'(m16);
      x.terms = 8'(mterms);
`ifdef SATURATE_EN
      x.sat24 = msat24;
      x.sat16 = msat16;
`else
      x.sat24 = 1'b0;
      x.sat16 = 1'b0;
`endif
      sb_q.push_back(x);
      model_clear();
    end
  endtask

  // Scoreboard: pops one expectation per acc_done_sig cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      if (done_sig) last_done_cyc = cyc;
      if (acc_done_sig) begin
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_done: acc_done_sig=1 with empty scoreboard, acc_result=%h", acc_result);
        end else begin
          e = sb_q.pop_front();
          last_r24 = e.r24;
          checks++;
          if (acc_result !== e.r24) begin
            errors++; $display("FAIL result24: got %h expected %h", acc_result, e.r24);
          end
          checks++;
          if (acc_terms !== e.terms) begin
            errors++; $display("FAIL terms: got %0d expected %0d", acc_terms, e.terms);
          end
          checks++;
          if (acc_sat !== e.sat24) begin
            errors++; $display("FAIL sat24: got %b expected %b", acc_sat, e.sat24);
          end
          checks++;
          if (acc_done_sig16 !== 1'b1 || acc_result16 !== e.r16) begin
            errors++; $display("FAIL result16: done=%b got %h expected %h", acc_done_sig16, acc_result16, e.r16);
          end
          checks++;
          if (acc_sat16 !== e.sat16) begin
            errors++; $display("FAIL sat16: got %b expected %b", acc_sat16, e.sat16);
          end
          checks++;
          if (cyc - last_done_cyc != 2) begin
            errors++; $display("FAIL done_latency: got %0d expected 2", cyc - last_done_cyc);
          end
        end
      end else if (acc_done_sig16) begin
        checks++; errors++;
        $display("FAIL done16_alone: acc_done_sig16=1 while acc_done_sig=0");
      end
    end
  end

  task automatic send_pair(input int a, input int b, input bit last);
    int n;
    bit ok;
    n = 0; ok = 0;
    @(negedge clk);
    in_valid = 1'b1; in_a = 8'(a); in_b = 8'(b); in_last = last;
    while (!ok && n < 200) begin
      if (in_ready) begin
        @(posedge clk);
        ok = 1;
      end else begin
        @(negedge clk);
        n++;
      end
    end
    #1 in_valid = 1'b0;
    if (!ok) begin
      checks++; errors++;
      $display("FAIL accept_timeout: in_ready=%b after %0d cycles, required 1", in_ready, n);
    end
    model_term(a, b, last);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (sb_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain_timeout: %0d results pending, required 0", sb_q.size());
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    #400;
    checks++;
    if ({in_ready, start_sig, acc_done_sig, acc_sat} !== 4'b0) begin
      errors++; $display("FAIL reset_ctl: got %b expected 0000", {in_ready, start_sig, acc_done_sig, acc_sat});
    end
    checks++;
    if ({A, B, acc_terms, acc_result} !== 48'h0) begin
      errors++; $display("FAIL reset_data: got %h expected 0", {A, B, acc_terms, acc_result});
    end
    checks++;
    if ({in_ready16, start_sig16, acc_done_sig16, acc_result16} !== 19'h0) begin
      errors++; $display("FAIL reset16: got %h expected 0", {in_ready16, start_sig16, acc_done_sig16, acc_result16});
    end
    #100 rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL idle_ready: got %b expected 1", in_ready);
    end
  endtask

  task automatic test_frame();
    mul_lat = 2;
    send_pair(2, 4, 0);
    send_pair(-4, 4, 1);
    wait_drain();
  endtask

  task automatic test_single();
    mul_lat = 3;
    send_pair(127, -127, 1);
    wait_drain();
  endtask

  task automatic test_sat16();
    mul_lat = 1;
    send_pair(-128, -128, 0);
    send_pair(-128, -128, 1);
    wait_drain();
  endtask

  task automatic test_hold_valid();
    int n;
    mul_lat = 4;
    send_pair(3, 5, 1);
    // Keep offering a different pair throughout ISSUE.
    in_valid = 1'b1; in_a = 8'd9; in_b = 8'd9; in_last = 1'b0;
    n = 0;
    @(negedge clk);
    while (start_sig && n < 50) begin
      checks++;
      if (in_ready !== 1'b0 || A !== 8'd3 || B !== 8'd5) begin
        errors++; $display("FAIL hold_issue: ready=%b A=%0d B=%0d expected 0/3/5", in_ready, A, B);
      end
      @(negedge clk);
      n++;
    end
    in_valid = 1'b0;
    checks++;
    if (n < 3 || n >= 50) begin
      errors++; $display("FAIL hold_issue_len: %0d ISSUE cycles, expected 3..49", n);
    end
    wait_drain();
    checks++;
    if (start_sig !== 1'b0 || A !== 8'd3) begin
      errors++; $display("FAIL hold_no_extra: start=%b A=%0d expected 0/3", start_sig, A);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    mul_lat = 6;
    send_pair(5, 5, 0);
    n = 0;
    while (!start_sig && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    checks++;
    if (start_sig !== 1'b1 || acc_result === 24'h0) begin
      errors++; $display("FAIL pre_reset: start=%b acc_result=%h expected 1/nonzero", start_sig, acc_result);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (start_sig !== 1'b0 || acc_result !== 24'h0 || acc_done_sig !== 1'b0 || in_ready !== 1'b0) begin
      errors++; $display("FAIL mid_reset: start=%b res=%h done=%b ready=%b expected all 0",
                         start_sig, acc_result, acc_done_sig, in_ready);
    end
    model_clear();
    sb_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    mul_lat = 2;
    send_pair(-127, -127, 1);
    wait_drain();
  endtask

  task automatic test_back_to_back();
    mul_lat = 1;
    send_pair(10, 10, 0);
    send_pair(20, -3, 1);
    send_pair(1, 1, 1);
    wait_drain();
    repeat (5) @(negedge clk);
    checks++;
    if (acc_result !== last_r24) begin
      errors++; $display("FAIL result_hold: got %h expected %h", acc_result, last_r24);
    end
    for (int f = 0; f < 4; f++) begin
      int nt;
      nt = int'($urandom_range(1, 5));
      for (int t = 0; t < nt; t++) begin
        mul_lat = int'($urandom_range(1, 4));
        send_pair(int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128, t == nt - 1);
      end
    end
    wait_drain();
  endtask

  task automatic test_counter_wrap();
    mul_lat = 1;
    for (int t = 0; t < 257; t++)
      send_pair(int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128, t == 256);
    wait_drain();
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_last = 1'b0;
    test_reset();
    test_frame();
    test_single();
    test_sat16();
    test_hold_valid();
    test_reset_mid();
    test_back_to_back();
    test_counter_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
